// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the sequence checker: FSM encoding and the
// saturation ceiling helper used by the error accumulators.
package sequence_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // All-ones value of a counter of the given width (width < 64).
    function automatic longint unsigned sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sequence_checker_popcount.sv
// Combinational population count of a BITS_WIDTH-wide vector.
module sequence_checker_popcount #(
    parameter int BITS_WIDTH = 5
) (
    input  logic [BITS_WIDTH-1:0]           vec_i,
    output logic [$clog2(BITS_WIDTH+1)-1:0] count_o
);

    localparam int PC_W = $clog2(BITS_WIDTH + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < BITS_WIDTH; i++) begin
            count_o = count_o + PC_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the wrapping increment sequence: acquires lock,
// flags mismatched words while locked and accumulates word/bit error counts.
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int BITS_WIDTH   = 5,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  clr_counts,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  bit_err_count
);

    localparam int MR_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(UNLOCK_COUNT + 1);
    localparam int PC_W = $clog2(BITS_WIDTH + 1);

    localparam logic [MR_W-1:0]      LOCK_TGT   = MR_W'(LOCK_COUNT);
    localparam logic [MS_W-1:0]      UNLOCK_TGT = MS_W'(UNLOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(sat_max(CNT_WIDTH));

    state_e                state_q, state_d;
    logic [BITS_WIDTH-1:0] expected_q, expected_d;
    logic                  seeded_q, seeded_d;
    logic [MR_W-1:0]       match_run_q, match_run_d;
    logic [MS_W-1:0]       miss_run_q, miss_run_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0]  bit_err_q, bit_err_d;

    logic                  hit;
    logic [PC_W-1:0]       bit_diff;
    logic [CNT_WIDTH:0]    bit_sum;
    logic [MR_W-1:0]       match_inc;
    logic [MS_W-1:0]       miss_inc;
    logic [CNT_WIDTH-1:0]  err_count_inc;
    logic [CNT_WIDTH-1:0]  bit_err_inc;

    sequence_checker_popcount #(
        .BITS_WIDTH (BITS_WIDTH)
    ) u_popcount (
        .vec_i   (data_in ^ expected_q),
        .count_o (bit_diff)
    );

    assign hit       = (data_in == expected_q);
    assign match_inc = match_run_q + MR_W'(1);
    assign miss_inc  = miss_run_q + MS_W'(1);

    // One guard bit on the bit-error sum turns overflow into saturation.
    assign bit_sum       = {1'b0, bit_err_q} + (CNT_WIDTH + 1)'(bit_diff);
    assign bit_err_inc   = bit_sum[CNT_WIDTH] ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
    assign err_count_inc = (err_count_q == CNT_MAX) ? CNT_MAX : err_count_q + CNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        seeded_d    = seeded_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_err_d   = bit_err_q;

        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    expected_d = data_in + BITS_WIDTH'(1);
                    if (!seeded_q) begin
                        seeded_d    = 1'b1;
                        match_run_d = '0;
                    end else if (hit) begin
                        if (match_inc == LOCK_TGT) begin
                            state_d     = LOCKED;
                            match_run_d = '0;
                            miss_run_d  = '0;
                        end else begin
                            match_run_d = match_inc;
                        end
                    end else begin
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running predictor so that slips show up as errors.
                    expected_d = expected_q + BITS_WIDTH'(1);
                    if (hit) begin
                        miss_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = err_count_inc;
                        bit_err_d   = bit_err_inc;
                        if (miss_inc == UNLOCK_TGT) begin
                            state_d     = SEARCH;
                            seeded_d    = 1'b0;
                            match_run_d = '0;
                            miss_run_d  = '0;
                        end else begin
                            miss_run_d = miss_inc;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_counts) begin
            err_count_d = '0;
            bit_err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            expected_q  <= '0;
            seeded_q    <= 1'b0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            seeded_q    <= seeded_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_err_q   <= bit_err_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign bit_err_count = bit_err_q;

endmodule
